// File: rtl/md_audio_i2s_if.sv
// Audio bus between the board core and the I2S output stage: mixed L/R words
// and controls in, parallel samples and the I2S pins out.
interface md_audio_i2s_if;
  logic [15:0] A_L;
  logic [15:0] A_R;
  logic [2:0]  vol;
  logic        mute;
  logic [15:0] samp_L;
  logic [15:0] samp_R;
  logic        sample_stb;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_data;

  modport master (
    output A_L, A_R, vol, mute,
    input  samp_L, samp_R, sample_stb, i2s_bclk, i2s_lrck, i2s_data
  );

  modport slave (
    input  A_L, A_R, vol, mute,
    output samp_L, samp_R, sample_stb, i2s_bclk, i2s_lrck, i2s_data
  );
endinterface

// File: rtl/md_audio_i2s.sv
// Boxcar-decimating audio output stage: averages 2^LOG2_WIN MCLK samples,
// attenuates/mutes, and serialises the result as a 64-BCLK Philips I2S frame.
module md_audio_i2s #(
  parameter int LOG2_WIN = 10
) (
  input  logic           MCLK,
  input  logic           ext_reset,
  md_audio_i2s_if.slave  aud
);

  localparam int ACC_W = 16 + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] CNT_ONE = 1;

  logic [LOG2_WIN-1:0]     cnt;
  logic [LOG2_WIN-1:0]     cnt_nxt;
  logic                    win_end;
  logic [5:0]              b_nxt;
  logic                    h_nxt;

  logic signed [ACC_W-1:0] acc_L;
  logic signed [ACC_W-1:0] acc_R;
  logic signed [ACC_W-1:0] sum_L;
  logic signed [ACC_W-1:0] sum_R;
  logic signed [15:0]      avg_L;
  logic signed [15:0]      avg_R;
  logic signed [15:0]      att_L;
  logic signed [15:0]      att_R;
  logic [15:0]             out_L;
  logic [15:0]             out_R;

  logic [15:0]             samp_L_q;
  logic [15:0]             samp_R_q;
  logic                    stb_q;
  logic [15:0]             ser_L;
  logic [15:0]             ser_R;
  logic [15:0]             ser_L_nxt;
  logic [15:0]             ser_R_nxt;

  logic                    bclk_q;
  logic                    lrck_q;
  logic                    data_q;
  logic                    lrck_nxt;
  logic                    data_nxt;

  // Pins are registered from the decode of the next count so they never glitch.
  always_comb begin
    cnt_nxt = cnt + CNT_ONE;
    win_end = &cnt;
    b_nxt   = cnt_nxt[LOG2_WIN-1 -: 6];
    h_nxt   = cnt_nxt[LOG2_WIN-7];

    sum_L = acc_L + {{LOG2_WIN{aud.A_L[15]}}, aud.A_L};
    sum_R = acc_R + {{LOG2_WIN{aud.A_R[15]}}, aud.A_R};
    avg_L = sum_L[LOG2_WIN +: 16];
    avg_R = sum_R[LOG2_WIN +: 16];
    // Shift kept separate from the mute select so it stays arithmetic.
    att_L = avg_L >>> aud.vol;
    att_R = avg_R >>> aud.vol;
    out_L = aud.mute ? 16'h0000 : att_L;
    out_R = aud.mute ? 16'h0000 : att_R;

    ser_L_nxt = win_end ? out_L : ser_L;
    ser_R_nxt = win_end ? out_R : ser_R;

    lrck_nxt = (b_nxt >= 6'd31) && (b_nxt != 6'd63);
    data_nxt = 1'b0;
    case (b_nxt[5:4])
      2'd0:    data_nxt = ser_L_nxt[~b_nxt[3:0]];
      2'd2:    data_nxt = ser_R_nxt[~b_nxt[3:0]];
      default: data_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      cnt      <= '0;
      acc_L    <= '0;
      acc_R    <= '0;
      samp_L_q <= '0;
      samp_R_q <= '0;
      ser_L    <= '0;
      ser_R    <= '0;
      stb_q    <= 1'b0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      data_q   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      stb_q  <= win_end;
      bclk_q <= h_nxt;
      lrck_q <= lrck_nxt;
      data_q <= data_nxt;
      ser_L  <= ser_L_nxt;
      ser_R  <= ser_R_nxt;
      if (win_end) begin
        acc_L    <= '0;
        acc_R    <= '0;
        samp_L_q <= out_L;
        samp_R_q <= out_R;
      end else begin
        acc_L <= sum_L;
        acc_R <= sum_R;
      end
    end
  end

  assign aud.samp_L     = samp_L_q;
  assign aud.samp_R     = samp_R_q;
  assign aud.sample_stb = stb_q;
  assign aud.i2s_bclk   = bclk_q;
  assign aud.i2s_lrck   = lrck_q;
  assign aud.i2s_data   = data_q;

endmodule

// File: tb/tb_md_audio_i2s.sv
// Self-checking bench for md_audio_i2s: per-window expected samples are queued
// from a floor-division model and popped on each sample_stb.
module tb_md_audio_i2s;
  localparam int LOG2_WIN = 10;
  localparam int WIN      = 1 << LOG2_WIN;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } samp_t;

  logic MCLK = 1'b0;
  logic ext_reset;

  int     tests_run    = 0;
  int     tests_failed = 0;
  samp_t  exp_q[$];
  int     m_cnt = 0;
  longint m_sum_l = 0;
  longint m_sum_r = 0;

  logic [63:0] cap_frame;
  int          cap_lr_rise;
  int          cap_lr_fall;
  int          cap_bclk_rises;
  bit          cap_period_ok;
  bit          cap_data_ok;

  md_audio_i2s_if aud ();

  md_audio_i2s #(.LOG2_WIN(LOG2_WIN)) dut (
    .MCLK      (MCLK),
    .ext_reset (ext_reset),
    .aud       (aud)
  );

  always #5 MCLK = ~MCLK;

  function automatic longint floor_div(input longint x, input longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic logic [15:0] model_out(input longint sum, input logic [2:0] vol,
                                            input logic mute);
    longint v;
    v = floor_div(floor_div(sum, longint'(WIN)), longint'(1) << vol);
    if (mute) return 16'h0000;
    return v[15:0];
  endfunction

  // One MCLK of input; the window model queues a result at window end and
  // the queue is popped whenever the DUT strobes.
  task automatic applyStimulus(input logic [15:0] a_l, input logic [15:0] a_r);
    samp_t s;
    aud.A_L = a_l;
    aud.A_R = a_r;
    m_sum_l += longint'($signed(a_l));
    m_sum_r += longint'($signed(a_r));
    if (m_cnt == WIN - 1) begin
      s.l = model_out(m_sum_l, aud.vol, aud.mute);
      s.r = model_out(m_sum_r, aud.vol, aud.mute);
      exp_q.push_back(s);
      m_sum_l = 0;
      m_sum_r = 0;
    end
    m_cnt = (m_cnt + 1) % WIN;
    @(negedge MCLK);
    if (aud.sample_stb === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL scoreboard_stb: strobe with samp_L=%h samp_R=%h but no sample expected",
                 aud.samp_L, aud.samp_R);
      end else begin
        s = exp_q.pop_front();
        if ({aud.samp_L, aud.samp_R} !== s) begin
          tests_failed++;
          $display("[TB] FAIL scoreboard_samp: got L=%h R=%h expected L=%h R=%h",
                   aud.samp_L, aud.samp_R, s.l, s.r);
        end
      end
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_sum_l = 0;
    m_sum_r = 0;
    exp_q.delete();
  endtask

  // Records one full frame of pin activity starting at cnt == 0.
  task automatic capture_frame(input logic [15:0] a_l, input logic [15:0] a_r);
    logic prev_l, prev_b, prev_d;
    int   last_rise, c;
    cap_frame      = '0;
    cap_lr_rise    = -1;
    cap_lr_fall    = -1;
    cap_bclk_rises = 0;
    cap_period_ok  = 1'b1;
    cap_data_ok    = 1'b1;
    last_rise      = -8;
    prev_l = aud.i2s_lrck;
    prev_b = aud.i2s_bclk;
    prev_d = aud.i2s_data;
    for (int i = 0; i < WIN; i++) begin
      c = m_cnt;
      if (c % 16 == 8) cap_frame[63 - c / 16] = aud.i2s_data;
      if (i > 0) begin
        if (!prev_l && aud.i2s_lrck) cap_lr_rise = c;
        if (prev_l && !aud.i2s_lrck) cap_lr_fall = c;
        if (!prev_b && aud.i2s_bclk) begin
          cap_bclk_rises++;
          if (c - last_rise != 16) cap_period_ok = 1'b0;
          last_rise = c;
        end
        if (aud.i2s_data !== prev_d && !(prev_b && !aud.i2s_bclk)) cap_data_ok = 1'b0;
      end
      prev_l = aud.i2s_lrck;
      prev_b = aud.i2s_bclk;
      prev_d = aud.i2s_data;
      applyStimulus(a_l, a_r);
    end
  endtask

  task automatic test_reset();
    int first_stb;
    ext_reset = 1'b1;
    aud.A_L   = 16'h1234;
    aud.A_R   = 16'hFEDC;
    aud.vol   = 3'd0;
    aud.mute  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge MCLK);
      tests_run++;
      if ({aud.samp_L, aud.samp_R, aud.sample_stb, aud.i2s_bclk, aud.i2s_lrck,
           aud.i2s_data} !== 36'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_outputs: cycle %0d got L=%h R=%h stb=%b bclk=%b lrck=%b data=%b expected all 0",
                 i, aud.samp_L, aud.samp_R, aud.sample_stb, aud.i2s_bclk, aud.i2s_lrck,
                 aud.i2s_data);
      end
    end
    ext_reset = 1'b0;
    model_reset();
    first_stb = -1;
    for (int k = 1; k <= WIN + 32 && first_stb < 0; k++) begin
      applyStimulus(16'h1234, 16'hFEDC);
      if (aud.sample_stb === 1'b1) first_stb = k;
    end
    tests_run++;
    if (first_stb != WIN) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_stb: strobe after %0d cycles, expected %0d", first_stb, WIN);
    end
    tests_run++;
    if ({aud.samp_L, aud.samp_R} !== 32'h1234FEDC) begin
      tests_failed++;
      $display("[TB] FAIL constant_samp: got L=%h R=%h expected L=1234 R=fedc",
               aud.samp_L, aud.samp_R);
    end
  endtask

  task automatic test_constant();
    capture_frame(16'h1234, 16'hFEDC);
    tests_run++;
    if (cap_frame !== {16'h1234, 16'h0000, 16'hFEDC, 16'h0000}) begin
      tests_failed++;
      $display("[TB] FAIL constant_frame: got %h expected 12340000fedc0000", cap_frame);
    end
  endtask

  task automatic test_serial_timing();
    capture_frame(16'h1234, 16'hFEDC);
    tests_run++;
    if (cap_lr_rise != 496) begin
      tests_failed++;
      $display("[TB] FAIL lrck_rise: at cnt %0d expected 496", cap_lr_rise);
    end
    tests_run++;
    if (cap_lr_fall != 1008) begin
      tests_failed++;
      $display("[TB] FAIL lrck_fall: at cnt %0d expected 1008", cap_lr_fall);
    end
    tests_run++;
    if (cap_bclk_rises != 64) begin
      tests_failed++;
      $display("[TB] FAIL bclk_count: got %0d rises expected 64", cap_bclk_rises);
    end
    tests_run++;
    if (cap_period_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bclk_period: got irregular spacing expected 16 MCLK");
    end
    tests_run++;
    if (cap_data_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL data_edges: got data change off a bclk fall expected none");
    end
  endtask

  task automatic test_average_floor();
    for (int i = 0; i < WIN; i++)
      applyStimulus(m_cnt[0] ? 16'h8000 : 16'h7FFF, 16'h0000);
    tests_run++;
    if (aud.samp_L !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL average_floor: got %h expected ffff", aud.samp_L);
    end
  endtask

  task automatic test_attenuation();
    aud.vol = 3'd3;
    for (int i = 0; i < WIN; i++) applyStimulus(16'hFF9C, 16'h0800);
    tests_run++;
    if ({aud.samp_L, aud.samp_R} !== 32'hFFF30100) begin
      tests_failed++;
      $display("[TB] FAIL attenuation: got L=%h R=%h expected L=fff3 R=0100",
               aud.samp_L, aud.samp_R);
    end
    aud.vol = 3'd0;
  endtask

  task automatic test_mute();
    aud.mute = 1'b1;
    for (int i = 0; i < WIN; i++) applyStimulus(16'h1234, 16'h5678);
    tests_run++;
    if ({aud.samp_L, aud.samp_R} !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL mute_samp: got L=%h R=%h expected 0", aud.samp_L, aud.samp_R);
    end
    capture_frame(16'h1234, 16'h5678);
    tests_run++;
    if (cap_frame !== 64'h0) begin
      tests_failed++;
      $display("[TB] FAIL mute_frame: got %h expected all zero", cap_frame);
    end
    aud.mute = 1'b0;
  endtask

  task automatic test_vol_midwindow();
    aud.vol = 3'd0;
    for (int i = 0; i < WIN; i++) begin
      if (m_cnt == 500) aud.vol = 3'd2;
      applyStimulus(16'h0400, 16'h0400);
    end
    tests_run++;
    if (aud.samp_L !== 16'h0100) begin
      tests_failed++;
      $display("[TB] FAIL vol_midwindow: got %h expected 0100", aud.samp_L);
    end
    aud.vol = 3'd5;
    for (int i = 0; i < WIN; i++) begin
      if (m_cnt == 512) begin
        tests_run++;
        if (aud.samp_L !== 16'h0100) begin
          tests_failed++;
          $display("[TB] FAIL vol_hold: got %h mid-window expected 0100", aud.samp_L);
        end
      end
      applyStimulus(16'h0400, 16'h0400);
    end
    aud.vol = 3'd0;
  endtask

  task automatic test_midframe_reset();
    int first_stb;
    while (m_cnt != 500) applyStimulus(16'h7000, 16'h7000);
    ext_reset = 1'b1;
    @(negedge MCLK);
    tests_run++;
    if ({aud.samp_L, aud.samp_R, aud.sample_stb, aud.i2s_bclk, aud.i2s_lrck,
         aud.i2s_data} !== 36'h0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset: got L=%h R=%h stb=%b bclk=%b lrck=%b data=%b expected all 0",
               aud.samp_L, aud.samp_R, aud.sample_stb, aud.i2s_bclk, aud.i2s_lrck, aud.i2s_data);
    end
    ext_reset = 1'b0;
    model_reset();
    first_stb = -1;
    for (int k = 1; k <= WIN + 32 && first_stb < 0; k++) begin
      applyStimulus(16'h0100, 16'hFF00);
      if (aud.sample_stb === 1'b1) first_stb = k;
    end
    tests_run++;
    if (first_stb != WIN) begin
      tests_failed++;
      $display("[TB] FAIL midframe_first_stb: strobe after %0d cycles, expected %0d", first_stb, WIN);
    end
    tests_run++;
    if ({aud.samp_L, aud.samp_R} !== 32'h0100FF00) begin
      tests_failed++;
      $display("[TB] FAIL midframe_samp: got L=%h R=%h expected L=0100 R=ff00",
               aud.samp_L, aud.samp_R);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_serial_timing();
    test_average_floor();
    test_attenuation();
    test_mute();
    test_vol_midwindow();
    test_midframe_reset();
    applyStimulus(16'h0000, 16'h0000);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL pending_samples: %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/md_audio_i2s.md
# md_audio_i2s

Audio output stage downstream of the Mega Drive board core. Consumes the board's per-MCLK mixed audio words (FM + PSG, signed 16-bit L/R). Decimates them by boxcar averaging over a power-of-two window, applies attenuation/mute, and serialises the result as a standard Philips I2S stream (64 BCLK per frame) for an external DAC. Also exposes the parallel samples with a strobe for on-chip consumers.

## Interface

Parameters:
- LOG2_WIN, default 10: window and frame length is 2^LOG2_WIN MCLK cycles. Legal range is 7..12. At 53.693 MHz, 10 gives 52.4 kHz.

Ports:
- MCLK  in  1  system clock; single clock domain.
- ext_reset  in  1  synchronous, active-high reset.
- A_L  in  16  signed left audio from board core, sampled every MCLK.
- A_R  in  16  signed right audio, sampled every MCLK.
- vol  in  3  attenuation; the average is arithmetically shifted right by vol.
- mute  in  1  1 forces output samples to 0.
- samp_L  out  16  last averaged, attenuated left sample.
- samp_R  out  16  same for right.
- sample_stb  out  1  one-cycle pulse when samp_L/samp_R update.
- i2s_bclk  out  1  bit clock, MCLK/2^(LOG2_WIN-6).
- i2s_lrck  out  1  word select; 0 = left, 1 = right.
- i2s_data  out  1  serial data, MSB first.

## Operation

- Free-running counter cnt[LOG2_WIN-1:0] increments every MCLK and wraps from all-ones to 0.
- Derived fields:
  - b = cnt[LOG2_WIN-1:LOG2_WIN-6] is the frame bit index, 0..63.
  - h = cnt[LOG2_WIN-7] is the BCLK phase.
- Accumulation:
  - acc_L/acc_R are signed, 16+LOG2_WIN bits wide. No overflow is possible.
  - For cnt != all-ones: acc <= acc + sext(A).
  - For cnt == all-ones: sum = acc + sext(A), acc <= 0.
  - avg = sum >>> LOG2_WIN (arithmetic, floor). Exactly 2^LOG2_WIN input samples contribute per window.
- Post-processing at window end:
  - out = mute ? 0 : (avg >>> vol). Result always fits 16 bits, so no saturation is needed.
  - vol and mute are sampled only on the window-end cycle; changes at other times take effect at the next window end.
- At the window-end edge, samp_L/samp_R and the internal serial holding registers ser_L/ser_R all load out.
- I2S frame, driven from ser_L/ser_R:
  - Left data: b=0..15 carry ser_L[15..0]; b=16..31 carry 0.
  - Right data: b=32..47 carry ser_R[15..0]; b=48..63 carry 0.
  - lrck is 1 for b in 31..62 and 0 for b in 63 and 0..30. It leads each channel MSB by one BCLK.
  - bclk = h. Data and lrck change only on bclk falling edges, i.e. when h goes 1→0 or on frame wrap.
- The frame emitted during window k+1 carries the average of window k.

## Timing

- sample_stb is high exactly in the cycle where cnt == 0 following a completed window. It never fires during reset or in the first window after reset.
- Latency: from the last contributing A sample to samp_L valid is 1 MCLK. From there to the MSB on i2s_data is 0 MCLK, because b=0 in the same cycle.
- i2s_bclk, i2s_lrck and i2s_data are driven directly from flops, glitch-free. Each flop is loaded with the decode of cnt+1, so during the cycle with counter value c the pins show decode(c).
- Reset (synchronous, any point in a frame):
  - On the next edge: cnt=0, acc=0, samp_L=samp_R=0, ser=0, sample_stb=0, bclk=0, lrck=0, data=0.
  - All outputs are held at these values while ext_reset=1.
  - The partially accumulated window is discarded.
  - The first sample_stb occurs 2^LOG2_WIN cycles after the first cycle with ext_reset=0.
- There is no handshake or backpressure; the consumer must accept data at the frame rate.

## Test plan

- Reset: ext_reset=1 for 5 cycles, A_L=0x1234 → all outputs 0 and no strobe. Release → first sample_stb exactly 1024 cycles later (LOG2_WIN=10).
- Constant input: A_L=0x1234, A_R=0xFEDC, vol=0, mute=0.
  - samp_L=0x1234, samp_R=0xFEDC.
  - Next frame i2s_data: left slot 0001001000110100 then 16 zeros; right slot 1111111011011100 then 16 zeros.
- Averaging floor: A_L alternates 0x7FFF/0x8000 every cycle → sum=-512 → samp_L=0xFFFF.
- Attenuation and mute:
  - A_L=-100 constant, vol=3 → samp_L=0xFFF3.
  - mute=1 → samp_L=0x0000 and the left slot is all zeros.
  - vol changed mid-window is applied only at that window's end.
- Serial timing (LOG2_WIN=10):
  - bclk period is 16 MCLK.
  - lrck rises at cnt=496 and falls at cnt=1008.
  - i2s_data transitions only coincident with bclk falling edges; 64 bclk cycles per frame.
- Mid-frame reset: assert ext_reset at cnt=500 for 1 cycle → all outputs 0 on the next edge. Next sample_stb is exactly 1024 cycles after release and reflects only post-reset inputs.
